// File: rtl/mdr_mem_if_pkg.sv
// -----------------------------------------------------------------------------
// mdr_pkg
// Shared definitions for the memory data register block: the transaction
// state encoding and the load-size encodings used on the size input.
// Size encoding: 2'b00 byte, 2'b01 halfword, 2'b1x full word (bit 1 set means
// "word", bit 0 is then don't-care).
// -----------------------------------------------------------------------------
package mdr_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RD_WAIT = 2'b01,
      WR_WAIT = 2'b10
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // True for any word-size encoding (2'b10 or 2'b11).
   function automatic logic is_word(input logic [1:0] size);
      return size[1];
   endfunction

endpackage

// File: rtl/mdr_mem_if_extend.sv
// -----------------------------------------------------------------------------
// mdr_extend
// Combinational size/sign extender for sub-word memory reads. Only
// instantiated by mdr_mem_if when MDR_SUBWORD_EN is defined.
//
// Ports:
//   i_size      load size (SZ_BYTE / SZ_HALF / word)
//   i_sign_ext  1 = replicate the sub-word sign bit, 0 = zero-fill
//   i_data      raw memory read data
//   o_data      extended result
// -----------------------------------------------------------------------------
module mdr_extend
   import mdr_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]        i_size,
   input  logic              i_sign_ext,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_data
);

   logic w_fill;

   // Start from an all-fill word and overlay the kept low bits; this avoids a
   // zero-width replication when DATA_W is exactly 16.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path through the block leaves it unassigned (which would infer a latch).
      w_fill = 1'b0;
      o_data = i_data;
      if (!is_word(i_size)) begin
         if (i_size == SZ_HALF) begin
            w_fill       = i_sign_ext & i_data[15];
            o_data       = {DATA_W{w_fill}};
            o_data[15:0] = i_data[15:0];
         end else begin
            w_fill       = i_sign_ext & i_data[7];
            o_data       = {DATA_W{w_fill}};
            o_data[7:0]  = i_data[7:0];
         end
      end
   end

endmodule

// File: rtl/mdr_mem_if.sv
// -----------------------------------------------------------------------------
// mdr_mem_if
// Memory data register with a request/acknowledge memory port. Loads from the
// datapath bus in one cycle, or runs a multi-cycle memory read/write through a
// three-state FSM that tolerates wait states and aborts after TIMEOUT cycles
// without an acknowledge.
//
// Configuration macro: MDR_SUBWORD_EN -- when defined, reads honour size and
// sign_ext (byte/halfword with sign or zero extension); otherwise every read
// loads the full DATA_W word and size/sign_ext are ignored.
//
// Ports:
//   clk, clr            clock, synchronous active-high reset
//   R_in, bus_in        load MDR from the bus (IDLE only)
//   read, write         start a memory read / write of MDR (IDLE only)
//   size, sign_ext      sub-word read control
//   mem_rdata, mem_ack  memory read data and completion
//   mem_req, mem_we     registered request and direction
//   mem_wdata, MDR_out  register contents
//   busy, done, err     status: not idle, success pulse, timeout pulse
// -----------------------------------------------------------------------------
module mdr_mem_if
   import mdr_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              R_in,
   input  logic              read,
   input  logic              write,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [DATA_W-1:0] bus_in,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] MDR_out,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int              CNT_W    = $clog2(TIMEOUT + 1);
   // The counter holds the number of completed no-ack cycles; seeing
   // TIMEOUT-1 with no ack on this edge means this edge is the TIMEOUT-th.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            r_state, w_state_nxt;
   logic [DATA_W-1:0] r_mdr,   w_mdr_nxt;
   logic              r_req,   w_req_nxt;
   logic              r_we,    w_we_nxt;
   logic              r_done,  w_done_nxt;
   logic              r_err,   w_err_nxt;
   logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
   logic [DATA_W-1:0] w_rdata_ext;

`ifdef MDR_SUBWORD_EN
   mdr_extend #(
      .DATA_W (DATA_W)
   ) u_extend (
      .i_size     (size),
      .i_sign_ext (sign_ext),
      .i_data     (mem_rdata),
      .o_data     (w_rdata_ext)
   );
`else
   logic w_unused;
   assign w_unused    = ^{size, sign_ext};
   assign w_rdata_ext = mem_rdata;
`endif

   // Next-state and next-output logic. done/err default low so they pulse
   // for exactly one cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_mdr_nxt   = r_mdr;
      w_req_nxt   = r_req;
      w_we_nxt    = r_we;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         IDLE: begin
            // read > write > R_in; mem_ack is ignored here.
            if (read) begin
               w_state_nxt = RD_WAIT;
               w_req_nxt   = 1'b1;
               w_we_nxt    = 1'b0;
               w_cnt_nxt   = '0;
            end else if (write) begin
               w_state_nxt = WR_WAIT;
               w_req_nxt   = 1'b1;
               w_we_nxt    = 1'b1;
               w_cnt_nxt   = '0;
            end else if (R_in) begin
               w_mdr_nxt   = bus_in;
            end
         end
         RD_WAIT, WR_WAIT: begin
            // An ack on the limit edge is checked first, so it wins.
            if (mem_ack) begin
               if (r_state == RD_WAIT) w_mdr_nxt = w_rdata_ext;
               w_state_nxt = IDLE;
               w_req_nxt   = 1'b0;
               w_we_nxt    = 1'b0;
               w_done_nxt  = 1'b1;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = IDLE;
               w_req_nxt   = 1'b0;
               w_we_nxt    = 1'b0;
               w_err_nxt   = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_req_nxt   = 1'b0;
            w_we_nxt    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (clr) begin
         r_state <= IDLE;
         r_mdr   <= '0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_mdr   <= w_mdr_nxt;
         r_req   <= w_req_nxt;
         r_we    <= w_we_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign MDR_out   = r_mdr;
   assign mem_wdata = r_mdr;
   assign mem_req   = r_req;
   assign mem_we    = r_we;
   assign done      = r_done;
   assign err       = r_err;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mdr_mem_if.sv
// -----------------------------------------------------------------------------
// tb_mdr_mem_if
// Self-checking bench for mdr_mem_if (DATA_W=32, TIMEOUT=15). A table of
// load/read/write operations with hand-computed results is applied in a loop,
// followed by hand-written sequences for reset, priority and ignore cases.
// Expected sub-word results depend on whether MDR_SUBWORD_EN is defined.
// -----------------------------------------------------------------------------
module tb_mdr_mem_if;

   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 15;
`ifdef MDR_SUBWORD_EN
   localparam bit SUB = 1'b1;
`else
   localparam bit SUB = 1'b0;
`endif

   typedef enum logic [1:0] {OP_LOAD, OP_READ, OP_WRITE} op_e;

   typedef struct {
      op_e         op;
      logic [31:0] data;      // bus_in for loads, mem_rdata for reads
      logic [1:0]  size;
      logic        sx;
      int          ack_k;     // ack on edge N+ack_k; 0 = never (timeout)
      logic [31:0] exp_mdr;
      logic        exp_done;
      logic        exp_err;
   } vec_t;

   logic              clk = 1'b0;
   logic              clr, R_in, read, write, sign_ext, mem_ack;
   logic [1:0]        size;
   logic [DATA_W-1:0] bus_in, mem_rdata;
   logic              mem_req, mem_we, busy, done, err;
   logic [DATA_W-1:0] mem_wdata, MDR_out;

   int total = 0;
   int bad   = 0;
   logic [31:0] model_mdr;
   vec_t vecs[13];

   mdr_mem_if #(
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .clr       (clr),
      .R_in      (R_in),
      .read      (read),
      .write     (write),
      .size      (size),
      .sign_ext  (sign_ext),
      .bus_in    (bus_in),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .MDR_out   (MDR_out),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      R_in = 1'b0; read = 1'b0; write = 1'b0; mem_ack = 1'b0;
   endtask

   task automatic check_status(input string tag, input logic e_busy, input logic e_req,
                               input logic e_done, input logic e_err);
      check({tag, ".busy"}, {31'b0, busy},    {31'b0, e_busy});
      check({tag, ".req"},  {31'b0, mem_req}, {31'b0, e_req});
      check({tag, ".done"}, {31'b0, done},    {31'b0, e_done});
      check({tag, ".err"},  {31'b0, err},     {31'b0, e_err});
   endtask

   task automatic apply(input int idx, input vec_t v);
      string tag;
      int    n_wait;
      tag = $sformatf("v%0d", idx);
      size     = v.size;
      sign_ext = v.sx;
      if (v.op == OP_LOAD) begin
         R_in = 1'b1; bus_in = v.data;
         tick();
         idle_inputs();
         check({tag, ".mdr"}, MDR_out, v.exp_mdr);
         check_status(tag, 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
         // R_in asserted alongside the strobe must lose to read/write.
         R_in  = 1'b1; bus_in = ~model_mdr;
         read  = (v.op == OP_READ);
         write = (v.op == OP_WRITE);
         tick();
         idle_inputs();
         check({tag, ".we0"}, {31'b0, mem_we}, {31'b0, v.op == OP_WRITE});
         check({tag, ".wdata"}, mem_wdata, model_mdr);
         n_wait = (v.ack_k == 0) ? TIMEOUT : v.ack_k;
         for (int i = 1; i <= n_wait; i++) begin
            mem_ack   = (i == v.ack_k);
            mem_rdata = (i == v.ack_k) ? v.data : 32'h5A5A_0F0F;
            tick();
            if (i < n_wait) begin
               check_status({tag, ".wait"}, 1'b1, 1'b1, 1'b0, 1'b0);
               check({tag, ".wait.mdr"}, MDR_out, model_mdr);
            end
         end
         mem_ack = 1'b0;
         check({tag, ".mdr"}, MDR_out, v.exp_mdr);
         check({tag, ".we"}, {31'b0, mem_we}, 32'd0);
         check_status({tag, ".end"}, 1'b0, 1'b0, v.exp_done, v.exp_err);
         tick();
         check_status({tag, ".after"}, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      model_mdr = v.exp_mdr;
   endtask

   initial begin
      //            op        data          size     sx  k   exp_mdr                                   done  err
      vecs[0]  = '{OP_LOAD,  32'h12345678, 2'b10,  1'b0, 0, 32'h12345678,                              1'b0, 1'b0};
      vecs[1]  = '{OP_READ,  32'hCAFEF00D, 2'b10,  1'b0, 4, 32'hCAFEF00D,                              1'b1, 1'b0};
      vecs[2]  = '{OP_READ,  32'h000000F0, 2'b00,  1'b1, 1, SUB ? 32'hFFFFFFF0 : 32'h000000F0,         1'b1, 1'b0};
      vecs[3]  = '{OP_READ,  32'h000000F0, 2'b00,  1'b0, 2, 32'h000000F0,                              1'b1, 1'b0};
      vecs[4]  = '{OP_READ,  32'h00008001, 2'b01,  1'b1, 1, SUB ? 32'hFFFF8001 : 32'h00008001,         1'b1, 1'b0};
      vecs[5]  = '{OP_READ,  32'h12348001, 2'b01,  1'b0, 1, SUB ? 32'h00008001 : 32'h12348001,         1'b1, 1'b0};
      vecs[6]  = '{OP_READ,  32'h9ABCDE7F, 2'b00,  1'b1, 1, SUB ? 32'h0000007F : 32'h9ABCDE7F,         1'b1, 1'b0};
      vecs[7]  = '{OP_LOAD,  32'hA5A5A5A5, 2'b10,  1'b0, 0, 32'hA5A5A5A5,                              1'b0, 1'b0};
      vecs[8]  = '{OP_WRITE, 32'h00000000, 2'b10,  1'b0, 2, 32'hA5A5A5A5,                              1'b1, 1'b0};
      vecs[9]  = '{OP_READ,  32'h11111111, 2'b10,  1'b0, 0, 32'hA5A5A5A5,                              1'b0, 1'b1};
      vecs[10] = '{OP_READ,  32'h0BADF00D, 2'b10,  1'b0, 15, 32'h0BADF00D,                             1'b1, 1'b0};
      vecs[11] = '{OP_WRITE, 32'h00000000, 2'b10,  1'b0, 0, 32'h0BADF00D,                              1'b0, 1'b1};
      vecs[12] = '{OP_READ,  32'h80FF7E01, 2'b11,  1'b1, 3, 32'h80FF7E01,                              1'b1, 1'b0};

      idle_inputs();
      clr = 1'b1; size = 2'b10; sign_ext = 1'b0;
      bus_in = '0; mem_rdata = '0;
      tick(); tick();
      check("rst.mdr", MDR_out, 32'h0);
      check("rst.we", {31'b0, mem_we}, 32'd0);
      check_status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      clr = 1'b0;
      model_mdr = '0;

      for (int i = 0; i < 13; i++) apply(i, vecs[i]);

      // mem_ack while idle is ignored.
      mem_ack = 1'b1; mem_rdata = 32'h77777777;
      tick();
      mem_ack = 1'b0;
      check("idle_ack.mdr", MDR_out, model_mdr);
      check_status("idle_ack", 1'b0, 1'b0, 1'b0, 1'b0);

      // read and write together: read wins. Strobes during RD_WAIT ignored.
      read = 1'b1; write = 1'b1;
      tick();
      idle_inputs();
      check("rw.we", {31'b0, mem_we}, 32'd0);
      check_status("rw.start", 1'b1, 1'b1, 1'b0, 1'b0);
      R_in = 1'b1; write = 1'b1; read = 1'b1; bus_in = 32'hFFFF0000;
      tick();
      check("busy_ign.mdr", MDR_out, model_mdr);
      check("busy_ign.we", {31'b0, mem_we}, 32'd0);
      tick();
      idle_inputs();
      mem_ack = 1'b1; mem_rdata = 32'h13572468;
      tick();
      mem_ack = 1'b0;
      check("rw.mdr", MDR_out, 32'h13572468);
      check_status("rw.end", 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check_status("rw.after", 1'b0, 1'b0, 1'b0, 1'b0);
      model_mdr = 32'h13572468;

      // clr in the middle of a read.
      R_in = 1'b1; bus_in = 32'hDEADBEEF;
      tick();
      idle_inputs();
      check("clr.load", MDR_out, 32'hDEADBEEF);
      read = 1'b1;
      tick();
      read = 1'b0;
      tick(); tick();
      check_status("clr.pre", 1'b1, 1'b1, 1'b0, 1'b0);
      clr = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h24682468;
      tick();
      clr = 1'b0; mem_ack = 1'b0;
      check("clr.mdr", MDR_out, 32'h0);
      check_status("clr", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check_status("clr.after", 1'b0, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mdr_mem_if.md
# mdr_mem_if

Parametrised memory data register with a request/acknowledge memory port, replacing the single-cycle MDR in the CPU datapath. Loads from the internal bus in one cycle and runs multi-cycle memory reads and writes through a small state machine with wait-state tolerance and a timeout. Loads can optionally be byte or halfword with sign or zero extension. Sits between the datapath bus and the memory subsystem; MDR_out drives the bus tristate/mux as before.

## Interface
- DATA_W, 32, register and memory data width (multiple of 16, ≥16)
- TIMEOUT, 15, max wait cycles for mem_ack before abort (≥1)
- clk  in  1  system clock, rising edge
- clr  in  1  synchronous, active-high reset
- R_in  in  1  load MDR from bus_in (ignored unless IDLE)
- read  in  1  start memory read (sampled in IDLE)
- write  in  1  start memory write of current MDR (sampled in IDLE)
- size  in  2  00 byte, 01 half, 1x word (read only)
- sign_ext  in  1  1 sign-extend, 0 zero-extend sub-word reads
- bus_in  in  DATA_W  datapath bus
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completes current request
- mem_req  out  1  request active (registered)
- mem_we  out  1  1 write, 0 read (valid while mem_req)
- mem_wdata  out  DATA_W  equals MDR contents
- MDR_out  out  DATA_W  register contents
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse after successful completion
- err  out  1  one-cycle pulse after timeout abort

## Operation
- States: IDLE, RD_WAIT, WR_WAIT. All outputs registered.
- clr: state→IDLE; MDR_out, mem_req, mem_we, done, err, wait counter → 0. Overrides everything, including mid-transaction.
- IDLE priority: read > write > R_in. read→RD_WAIT, mem_req=1, mem_we=0. write→WR_WAIT, mem_req=1, mem_we=1. R_in alone→MDR_out=bus_in, stay IDLE, no done.
- read/write/R_in while busy are ignored (not queued). mem_ack in IDLE ignored.
- RD_WAIT, mem_ack=1: MDR_out=extend(mem_rdata), mem_req=0, done=1 next cycle, →IDLE.
- WR_WAIT, mem_ack=1: mem_req=0, mem_we=0, done=1 next cycle, →IDLE; MDR unchanged.
- Wait counter clears on entry to a wait state, increments each cycle without ack; when count reaches TIMEOUT with no ack: mem_req=0, err=1 next cycle, →IDLE, MDR unchanged. Ack on the same edge as the limit wins (success).
- Extension: byte uses bits [7:0], half [15:0]; upper bits = sign bit if sign_ext else 0. Word: unchanged.

## Timing
- Bus load: R_in sampled at edge N, MDR_out valid after edge N.
- Read/write: strobe at edge N → mem_req high after N. Ack sampled at edge N+k (k≥1) → MDR update and mem_req low after N+k, done high for cycle after N+k. Minimum 2 edges strobe-to-data.
- Timeout: no ack through edge N+TIMEOUT → err pulse after that edge; new strobe accepted at the following edge.
- done and err never both high; busy low in the done/err cycle.

## Configuration
- MDR_SUBWORD_EN defined: size and sign_ext honoured as above.
- Undefined: size and sign_ext ignored; every read loads full DATA_W word; extension logic absent.

## Structure
- Package mdr_pkg: state enum (IDLE, RD_WAIT, WR_WAIT), size encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
- Sub-module mdr_extend: combinational size/sign extender, instantiated only under MDR_SUBWORD_EN.

## Test plan
- clr with MDR=0xDEADBEEF mid RD_WAIT → next cycle MDR_out=0, mem_req=0, busy=0, no done.
- R_in=1, bus_in=0x12345678 in IDLE → MDR_out=0x12345678 after one edge; read with mem_ack after 3 waits, mem_rdata=0xCAFEF00D, size=word → MDR_out=0xCAFEF00D, single done pulse.
- MDR_SUBWORD_EN: read byte 0x000000F0, sign_ext=1 → 0xFFFFFFF0; sign_ext=0 → 0x000000F0; half 0x00008001 sign_ext=1 → 0xFFFF8001.
- write with MDR=0xA5A5A5A5 → mem_req=1, mem_we=1, mem_wdata=0xA5A5A5A5 until ack; MDR unchanged; done pulse.
- No ack for TIMEOUT=15 cycles → err pulse, MDR unchanged, mem_req low; ack at exactly cycle 15 → done, no err.
- read and write asserted together in IDLE → read performed; R_in and write during RD_WAIT → ignored.
